mem_test_monitor: RTL and testbench

//   Synthesizable pass/fail checker for CPU self-test programs. Snoops the
//   CPU data-memory write bus (mem_we/mem_addr/mem_data between RV32 and dpram).

---
 rtl/mem_test_monitor.sv | 135 +++++++++++++
 tb/tb_mem_test_monitor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_test_monitor.sv
// Snoops CPU stores to MON_ADDR and checks them in order against exp_data_i; optional MON_CAPTURE_EN records the failing store.
// Verdict registered one cycle after the deciding store; no backpressure, the store bus is observed passively.
module mem_test_monitor #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 32,
  parameter int                 N_CHK    = 4,
  parameter logic [ADDR_W-1:0]  MON_ADDR = 'h40,
  parameter int                 TIMEOUT  = 100000,
  parameter int                 CNT_W    = 32,
  localparam int                IDX_W    = (N_CHK > 1) ? $clog2(N_CHK) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    mem_we_i,
  input  logic [ADDR_W-1:0]       mem_addr_i,
  input  logic [DATA_W-1:0]       mem_data_i,
  input  logic [N_CHK*DATA_W-1:0] exp_data_i,
  output logic                    done_o,
  output logic                    pass_o,
  output logic                    fail_o,
  output logic                    timeout_o,
  output logic [IDX_W-1:0]        chk_idx_o,
  output logic [CNT_W-1:0]        cycles_o,
  output logic [DATA_W-1:0]       fail_data_o,
  output logic [IDX_W-1:0]        fail_idx_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TMO  = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHK - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               TMO_EN   = (TIMEOUT != 0);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cycles;
  logic               r_done;
  logic               r_pass;
  logic               r_fail;
  logic               r_tmo;
  logic               w_hit;
  logic               w_match;
  logic [DATA_W-1:0]  w_exp;

  assign w_hit   = mem_we_i && (mem_addr_i == MON_ADDR);
  assign w_exp   = exp_data_i[r_idx*DATA_W +: DATA_W];
  assign w_match = (mem_data_i == w_exp);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // A hit in the same cycle as the watchdog limit takes priority.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_hit) begin
          if (!w_match)               w_state_nxt = ST_FAIL;
          else if (r_idx == LAST_IDX) w_state_nxt = ST_PASS;
        end else if (TMO_EN && (r_cycles == TMO_LAST)) begin
          w_state_nxt = ST_TMO;
        end
      end
      default: ;
    endcase
    if (start_i) w_state_nxt = ST_RUN;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx    <= '0;
      r_cycles <= '0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_fail   <= 1'b0;
      r_tmo    <= 1'b0;
    end else if (start_i) begin
      r_idx    <= '0;
      r_cycles <= '0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_fail   <= 1'b0;
      r_tmo    <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (r_cycles != '1)                          r_cycles <= r_cycles + 1'b1;
      if (w_hit && w_match && (r_idx != LAST_IDX)) r_idx    <= r_idx + 1'b1;
      r_done <= (w_state_nxt != ST_RUN);
      r_pass <= (w_state_nxt == ST_PASS);
      r_fail <= (w_state_nxt == ST_FAIL);
      r_tmo  <= (w_state_nxt == ST_TMO);
    end
  end

`ifdef MON_CAPTURE_EN
  logic [DATA_W-1:0] r_fail_data;
  logic [IDX_W-1:0]  r_fail_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fail_data <= '0;
      r_fail_idx  <= '0;
    end else if (start_i) begin
      r_fail_data <= '0;
      r_fail_idx  <= '0;
    end else if ((r_state == ST_RUN) && (w_state_nxt == ST_FAIL)) begin
      r_fail_data <= mem_data_i;
      r_fail_idx  <= r_idx;
    end
  end

  assign fail_data_o = r_fail_data;
  assign fail_idx_o  = r_fail_idx;
`else
  assign fail_data_o = '0;
  assign fail_idx_o  = '0;
`endif

  assign done_o    = r_done;
  assign pass_o    = r_pass;
  assign fail_o    = r_fail;
  assign timeout_o = r_tmo;
  assign chk_idx_o = r_idx;
  assign cycles_o  = r_cycles;

endmodule

// File: tb/tb_mem_test_monitor.sv
// Directed bench for mem_test_monitor: N_CHK=2, exp={0x31,0x10}, MON_ADDR=0x40, TIMEOUT=50.
module tb_mem_test_monitor;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NC = 2;
  localparam int TO = 50;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           start_i;
  logic           mem_we_i;
  logic [AW-1:0]  mem_addr_i;
  logic [DW-1:0]  mem_data_i;
  logic [NC*DW-1:0] exp_data_i;
  logic           done_o, pass_o, fail_o, timeout_o;
  logic           chk_idx_o;
  logic [31:0]    cycles_o;
  logic [DW-1:0]  fail_data_o;
  logic           fail_idx_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        pass;
    logic        fail;
    logic        tmo;
    logic        idx;
    logic [31:0] cyc;
    logic [31:0] fdata;
    logic        fidx;
  } exp_t;

  exp_t sb_q[$];

  mem_test_monitor #(
    .DATA_W(DW), .ADDR_W(AW), .N_CHK(NC), .MON_ADDR(32'h40), .TIMEOUT(TO), .CNT_W(32)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .exp_data_i(exp_data_i),
    .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o),
    .chk_idx_o(chk_idx_o), .cycles_o(cycles_o),
    .fail_data_o(fail_data_o), .fail_idx_o(fail_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Inputs change just after a falling edge; outputs are read at falling edges.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  task automatic store(input logic we, input logic [31:0] addr, input logic [31:0] data);
    mem_we_i   = we;
    mem_addr_i = addr;
    mem_data_i = data;
    @(negedge clk_i);
    mem_we_i   = 1'b0;
    mem_addr_i = '0;
    mem_data_i = '0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic push_exp(input logic p, input logic f, input logic t, input logic idx,
                          input logic [31:0] cyc, input logic [31:0] fd, input logic fi);
    exp_t e;
    e.pass = p; e.fail = f; e.tmo = t; e.idx = idx; e.cyc = cyc;
`ifdef MON_CAPTURE_EN
    e.fdata = fd; e.fidx = fi;
`else
    e.fdata = '0; e.fidx = 1'b0;
`endif
    sb_q.push_back(e);
  endtask

  task automatic check_verdict(input string tag);
    exp_t e;
    for (int i = 0; i < 200 && !done_o; i++) @(negedge clk_i);
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_pass"},  32'(pass_o),    32'(e.pass));
      chk({tag, "_fail"},  32'(fail_o),    32'(e.fail));
      chk({tag, "_tmo"},   32'(timeout_o), 32'(e.tmo));
      chk({tag, "_idx"},   32'(chk_idx_o), 32'(e.idx));
      chk({tag, "_cyc"},   cycles_o,       e.cyc);
      chk({tag, "_fdata"}, fail_data_o,    e.fdata);
      chk({tag, "_fidx"},  32'(fail_idx_o), 32'(e.fidx));
      idle(3);
      chk({tag, "_cyc_frozen"}, cycles_o, e.cyc);
      chk({tag, "_sticky"}, 32'({done_o, pass_o, fail_o, timeout_o}),
          32'({1'b1, e.pass, e.fail, e.tmo}));
    end
  endtask

  initial begin
    rst_ni     = 1'b0;
    start_i    = 1'b0;
    mem_we_i   = 1'b0;
    mem_addr_i = '0;
    mem_data_i = '0;
    exp_data_i = {32'h10, 32'h31};
    idle(2);
    chk("rst_flags", 32'({done_o, pass_o, fail_o, timeout_o, chk_idx_o}), 32'd0);
    chk("rst_cyc", cycles_o, 32'd0);
    rst_ni = 1'b1;
    idle(1);

    // Stores while idle are ignored.
    store(1'b1, 32'h40, 32'h31);
    chk("idle_ignore", 32'({done_o, chk_idx_o}), 32'd0);

    // 1: in-order pass with gaps between checkpoints
    pulse_start();
    chk("t1_start_cyc", cycles_o, 32'd0);
    idle(2);
    store(1'b1, 32'h40, 32'h31);
    chk("t1_idx_after_k0", 32'(chk_idx_o), 32'd1);
    chk("t1_not_done", 32'(done_o), 32'd0);
    idle(3);
    push_exp(1'b1, 1'b0, 1'b0, 1'b1, 32'd7, 32'd0, 1'b0);
    store(1'b1, 32'h40, 32'h10);
    chk("t1_pass_next_cycle", 32'(pass_o), 32'd1);
    check_verdict("t1");

    // 2: restart from PASS clears flags on the start edge, then mismatch on k1
    pulse_start();
    chk("t2_flags_cleared", 32'({done_o, pass_o, fail_o, timeout_o}), 32'd0);
    store(1'b1, 32'h40, 32'h31);
    push_exp(1'b0, 1'b1, 1'b0, 1'b1, 32'd2, 32'h11, 1'b1);
    store(1'b1, 32'h40, 32'h11);
    check_verdict("t2");

    // 3: only non-hits -> watchdog
    push_exp(1'b0, 1'b0, 1'b1, 1'b0, 32'd50, 32'd0, 1'b0);
    pulse_start();
    for (int i = 0; i < 60; i++) begin
      case (i % 3)
        0:       store(1'b1, 32'h44, 32'h31);
        1:       store(1'b1, 32'h3C, 32'h31);
        default: store(1'b0, 32'h40, 32'h31);
      endcase
      if (i == 48) chk("t3_no_early_tmo", 32'(done_o), 32'd0);
    end
    check_verdict("t3");

    // 4: final match sampled in cycle 49 beats the watchdog
    pulse_start();
    store(1'b1, 32'h40, 32'h31);
    idle(48);
    chk("t4_cyc_before", cycles_o, 32'd49);
    push_exp(1'b1, 1'b0, 1'b0, 1'b1, 32'd50, 32'd0, 1'b0);
    store(1'b1, 32'h40, 32'h10);
    check_verdict("t4");

    // 5: start mid-RUN restarts index and counter
    pulse_start();
    store(1'b1, 32'h40, 32'h31);
    idle(4);
    pulse_start();
    chk("t5_idx_restart", 32'(chk_idx_o), 32'd0);
    chk("t5_cyc_restart", cycles_o, 32'd0);
    push_exp(1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'h10, 1'b0);
    store(1'b1, 32'h40, 32'h10);
    check_verdict("t5");

    // 6: asynchronous reset mid-RUN
    pulse_start();
    store(1'b1, 32'h40, 32'h31);
    idle(2);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_async_flags", 32'({done_o, pass_o, fail_o, timeout_o, chk_idx_o}), 32'd0);
    chk("t6_async_cyc", cycles_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    store(1'b1, 32'h40, 32'h31);
    store(1'b1, 32'h40, 32'h10);
    chk("t6_ignored_idx", 32'({done_o, chk_idx_o}), 32'd0);
    chk("t6_ignored_cyc", cycles_o, 32'd0);

    // Hit coincident with start is not counted.
    start_i    = 1'b1;
    mem_we_i   = 1'b1;
    mem_addr_i = 32'h40;
    mem_data_i = 32'h31;
    @(negedge clk_i);
    start_i  = 1'b0;
    mem_we_i = 1'b0;
    chk("start_hit_ignored", 32'(chk_idx_o), 32'd0);
    store(1'b1, 32'h40, 32'h31);
    push_exp(1'b1, 1'b0, 1'b0, 1'b1, 32'd2, 32'd0, 1'b0);
    store(1'b1, 32'h40, 32'h10);
    check_verdict("t7");

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
